// File: rtl/nco_decim_fifo_if.sv
// rtl/nco_decim_fifo_if.sv - sample-in / result-out stream bundle for nco_decim_fifo
interface nco_decim_fifo_if #(
  parameter int DW = 32
);
  logic          in_en;
  logic [DW-1:0] in_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  modport master (output in_en, output in_data, output out_ready,
                  input  out_data, input out_valid);
  modport slave  (input  in_en, input in_data, input out_ready,
                  output out_data, output out_valid);
endinterface

// File: rtl/nco_decim_fifo.sv
// rtl/nco_decim_fifo.sv - accumulate-and-dump decimator (R=1,2,4,8) feeding a FWFT result FIFO
module nco_decim_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  nco_decim_fifo_if.slave          bus,
  input  logic [1:0]               dec_sel,
  input  logic                     ovf_clr,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf
);
  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int ACCW = DW + 3;

  logic signed [ACCW-1:0] acc_q, acc_d, sum;
  logic [2:0]             cnt_q, cnt_d, last_idx;
  logic [1:0]             ratio_q, ratio_d, sel_eff;
  logic [DW-1:0]          result;
  logic                   blk_start, dump, pop, full, wr_en, ovf_set;

  logic [DW-1:0]          mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q, rd_next;
  logic [LW-1:0]          level_q, level_d;
  logic [DW-1:0]          head_q, head_d;
  logic                   ovf_q, ovf_d;

  always_comb begin
    blk_start = (cnt_q == 3'd0);
    // The ratio is taken live from dec_sel only on a block's first sample.
    sel_eff   = blk_start ? dec_sel : ratio_q;
    case (sel_eff)
      2'd0:    last_idx = 3'd0;
      2'd1:    last_idx = 3'd1;
      2'd2:    last_idx = 3'd3;
      default: last_idx = 3'd7;
    endcase
    sum    = (blk_start ? {ACCW{1'b0}} : acc_q) + {{3{bus.in_data[DW-1]}}, bus.in_data};
    result = DW'(sum >>> sel_eff);
    dump   = bus.in_en && (cnt_q == last_idx);

    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ratio_d = ratio_q;
    if (bus.in_en) begin
      ratio_d = sel_eff;
      if (dump) begin
        acc_d = '0;
        cnt_d = 3'd0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 3'd1;
      end
    end

    full    = (level_q == LW'(DEPTH));
    pop     = (level_q != '0) && bus.out_ready;
    wr_en   = dump && (!full || pop);
    ovf_set = dump && full && !pop;
    level_d = level_q + LW'(wr_en) - LW'(pop);
    rd_next = rd_ptr_q + AW'(1);

    // Head register keeps its last value once the FIFO drains.
    head_d = head_q;
    if (wr_en && level_q == '0)
      head_d = result;
    else if (pop) begin
      if (level_q > LW'(1))
        head_d = mem_q[rd_next];
      else if (wr_en)
        head_d = result;
    end

    ovf_d = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= '0;
      cnt_q    <= 3'd0;
      ratio_q  <= dec_sel;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      ratio_q  <= ratio_d;
      wr_ptr_q <= wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_q <= pop ? rd_next : rd_ptr_q;
      level_q  <= level_d;
      head_q   <= head_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_en)
      mem_q[wr_ptr_q] <= result;
  end

  assign bus.out_data  = head_q;
  assign bus.out_valid = (level_q != '0);
  assign level         = level_q;
  assign ovf           = ovf_q;
endmodule

// File: tb/tb_nco_decim_fifo.sv
// tb/tb_nco_decim_fifo.sv - directed and randomized checks of nco_decim_fifo against a queue model
module tb_nco_decim_fifo;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] dec_sel;
  logic       ovf_clr;
  logic [3:0] level;
  logic       ovf;
  int         checks = 0;
  int         errors = 0;

  nco_decim_fifo_if #(.DW(32)) bus ();

  nco_decim_fifo #(.DW(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .dec_sel(dec_sel),
    .ovf_clr(ovf_clr), .level(level), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference model: block sum in wide arithmetic, FIFO as a queue.
  logic [31:0] mq[$];
  int          blk_n;
  int          blk_sel;
  longint      blk_sum;
  logic        m_ovf;
  logic [31:0] m_head;

  task automatic model_edge();
    logic        do_pop, do_push, ovf_now;
    logic [31:0] val;
    if (!rst_n) begin
      mq.delete(); blk_n = 0; blk_sum = 0; m_ovf = 1'b0; m_head = '0;
      return;
    end
    do_pop = (mq.size() > 0) && bus.out_ready;
    do_push = 1'b0; ovf_now = 1'b0; val = '0;
    if (bus.in_en) begin
      if (blk_n == 0) begin blk_sel = int'(dec_sel); blk_sum = 0; end
      blk_sum += longint'($signed(bus.in_data));
      blk_n++;
      if (blk_n == (1 << blk_sel)) begin
        val = 32'(blk_sum >>> blk_sel);
        do_push = 1'b1; blk_n = 0;
      end
    end
    if (do_push && mq.size() == DEPTH && !do_pop) ovf_now = 1'b1;
    if (do_pop) void'(mq.pop_front());
    if (do_push && !ovf_now) mq.push_back(val);
    if (ovf_now) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    if (mq.size() > 0) m_head = mq[0];
  endtask

  task automatic cycle(input logic en, input logic [31:0] d, input logic [1:0] sel,
                       input logic rdy, input logic clr);
    bus.in_en = en; bus.in_data = d; dec_sel = sel; bus.out_ready = rdy; ovf_clr = clr;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 32'd0, 2'd0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycle(1'b0, 32'd0, 2'd0, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 2'd0, 1'b0, 1'b0);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.out_data !== 32'd0) begin errors++; $display("FAIL reset_data got %0h exp 0", bus.out_data); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf); end
    rst_n = 1'b1;
  endtask

  task automatic test_pass_through();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 32'(i), 2'd0, 1'b1, 1'b0);
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'(i) || level > 4'd1) begin
        errors++; $display("FAIL pass_through[%0d] got v=%b d=%0d lvl=%0d exp v=1 d=%0d lvl<=1", i, bus.out_valid, bus.out_data, level, i);
      end
    end
    drain();
  endtask

  task automatic test_averaging();
    int smp[8] = '{1, 2, 3, 4, 10, 10, 10, 11};
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 32'(smp[i]), 2'd2, 1'b1, 1'b0);
      if (i % 4 != 3) begin
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL avg_idle[%0d] got v=%b exp 0", i, bus.out_valid); end
      end else begin
        checks++; if (bus.out_data !== (i == 3 ? 32'd2 : 32'd10) || bus.out_valid !== 1'b1) begin
          errors++; $display("FAIL avg_result[%0d] got %0d exp %0d", i, bus.out_data, (i == 3 ? 2 : 10));
        end
      end
    end
    drain();
  endtask

  task automatic test_neg_rounding();
    int smp[4] = '{-1, -2, -3, 4};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 32'(smp[i]), 2'd1, 1'b1, 1'b0);
      if (i == 1) begin
        checks++; if (bus.out_data !== 32'hFFFF_FFFE) begin errors++; $display("FAIL neg_round_a got %0h exp fffffffe", bus.out_data); end
      end else if (i == 3) begin
        checks++; if (bus.out_data !== 32'd0 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL neg_round_b got %0h exp 0", bus.out_data); end
      end
    end
    drain();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, 32'(100 + i), 2'd0, 1'b0, 1'b0);
      if (i == 7) begin
        checks++; if (level !== 4'd8 || ovf !== 1'b0) begin errors++; $display("FAIL ovf_fill got lvl=%0d ovf=%b exp lvl=8 ovf=0", level, ovf); end
      end
    end
    checks++; if (level !== 4'd8 || ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got lvl=%0d ovf=%b exp lvl=8 ovf=1", level, ovf); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus.out_data !== 32'(100 + i)) begin errors++; $display("FAIL ovf_drain[%0d] got %0d exp %0d", i, bus.out_data, 100 + i); end
      cycle(1'b0, 32'd0, 2'd0, 1'b1, 1'b0);
    end
    checks++; if (level !== 4'd0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL ovf_lost got lvl=%0d v=%b exp 0 0", level, bus.out_valid); end
    cycle(1'b0, 32'd0, 2'd0, 1'b0, 1'b1);
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b exp 0", ovf); end
    for (int i = 0; i < 8; i++) cycle(1'b1, 32'(i), 2'd0, 1'b0, 1'b0);
    cycle(1'b1, 32'd99, 2'd0, 1'b0, 1'b1);
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %b exp 1", ovf); end
    cycle(1'b0, 32'd0, 2'd0, 1'b0, 1'b1);
    drain();
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 8; i++) cycle(1'b1, 32'(200 + i), 2'd0, 1'b0, 1'b0);
    cycle(1'b1, 32'd208, 2'd0, 1'b1, 1'b0);
    checks++; if (level !== 4'd8 || ovf !== 1'b0 || bus.out_data !== 32'd201) begin
      errors++; $display("FAIL full_pushpop got lvl=%0d ovf=%b d=%0d exp 8 0 201", level, ovf, bus.out_data);
    end
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus.out_data !== 32'(201 + i)) begin errors++; $display("FAIL full_drain[%0d] got %0d exp %0d", i, bus.out_data, 201 + i); end
      cycle(1'b0, 32'd0, 2'd0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_ratio_change();
    cycle(1'b1, 32'd1, 2'd2, 1'b1, 1'b0);
    cycle(1'b1, 32'd1, 2'd2, 1'b1, 1'b0);
    cycle(1'b1, 32'd5, 2'd0, 1'b1, 1'b0);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ratio_hold got v=%b exp 0", bus.out_valid); end
    cycle(1'b1, 32'd5, 2'd0, 1'b1, 1'b0);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd3) begin errors++; $display("FAIL ratio_block got %0d exp 3", bus.out_data); end
    cycle(1'b1, 32'd7, 2'd0, 1'b1, 1'b0);
    checks++; if (bus.out_data !== 32'd7) begin errors++; $display("FAIL ratio_next_a got %0d exp 7", bus.out_data); end
    cycle(1'b1, 32'd9, 2'd0, 1'b1, 1'b0);
    checks++; if (bus.out_data !== 32'd9) begin errors++; $display("FAIL ratio_next_b got %0d exp 9", bus.out_data); end
    drain();
  endtask

  task automatic test_reset_mid_block();
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'd4, 2'd2, 1'b1, 1'b0);
    rst_n = 1'b0;
    cycle(1'b0, 32'd0, 2'd2, 1'b1, 1'b0);
    rst_n = 1'b1;
    checks++; if (level !== 4'd0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_empty got lvl=%0d v=%b exp 0 0", level, bus.out_valid); end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 32'd8, 2'd2, 1'b1, 1'b0);
      if (i == 2) begin
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_partial got v=%b exp 0", bus.out_valid); end
      end
    end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd8) begin errors++; $display("FAIL midrst_fresh got %0d exp 8", bus.out_data); end
    drain();
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      cycle($urandom_range(0, 3) != 0, $urandom, 2'($urandom_range(0, 3)),
            $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
      rst_n = 1'b1;
      checks++; if (bus.out_valid !== (mq.size() > 0) || level !== 4'(mq.size()) || ovf !== m_ovf || bus.out_data !== m_head) begin
        errors++; $display("FAIL random[%0d] got v=%b lvl=%0d ovf=%b d=%h exp v=%b lvl=%0d ovf=%b d=%h",
                           n, bus.out_valid, level, ovf, bus.out_data, mq.size() > 0, mq.size(), m_ovf, m_head);
      end
    end
  endtask

  initial begin
    bus.in_en = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    dec_sel = 2'd0; ovf_clr = 1'b0; rst_n = 1'b0;
    blk_n = 0; blk_sel = 0; blk_sum = 0; m_ovf = 1'b0; m_head = '0;
    #1;
    test_reset();
    test_pass_through();
    test_averaging();
    test_neg_rounding();
    test_overflow();
    test_full_push_pop();
    test_ratio_change();
    test_reset_mid_block();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
